// File: rtl/msx2_ram_access_if.sv
//----------------------------------------------------------------------------
// Module : msx2_ram_access_if
// Brief  : CPU-side bus, mapper inputs and external RAM controller handshake
//          for the MSX2 RAM access block.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface msx2_ram_access_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_mreq;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        sel;
    logic [7:0]  segment;
    logic [26:0] base_addr;
    logic        ram_req;
    logic        ram_rnw;
    logic [26:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_ack;
    logic [7:0]  ram_dout;
    logic [7:0]  q;
    logic        wait_n;
    logic        err;

    // Driver of CPU strobes and RAM controller responses
    modport master (
        output cpu_addr, cpu_data, cpu_mreq, cpu_rd, cpu_wr, sel, segment,
               base_addr, ram_ack, ram_dout,
        input  ram_req, ram_rnw, ram_addr, ram_din, q, wait_n, err
    );

    // The RAM access block itself
    modport slave (
        input  cpu_addr, cpu_data, cpu_mreq, cpu_rd, cpu_wr, sel, segment,
               base_addr, ram_ack, ram_dout,
        output ram_req, ram_rnw, ram_addr, ram_din, q, wait_n, err
    );
endinterface

`default_nettype wire

// File: rtl/msx2_ram_access.sv
//----------------------------------------------------------------------------
// Module : msx2_ram_access
// Brief  : Bridges one MSX2 CPU memory strobe to one external RAM transaction.
//          Optional macro MSX2_RAM_ACCESS_TIMEOUT_EN adds a 255-cycle abort.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module msx2_ram_access (
    input  wire logic          clk,
    input  wire logic          reset,
    msx2_ram_access_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        served;
    logic        abandoned;
    logic [7:0]  data_reg;
    logic [26:0] addr_reg;
    logic        rnw_reg;
    logic [7:0]  din_reg;

    logic        acc;
    logic        start;
    logic        acked;
    logic        timed_out;
    logic        unused_page;

    assign acc         = bus.sel & bus.cpu_mreq & (bus.cpu_rd | bus.cpu_wr);
    assign start       = (state == IDLE) & acc & ~served;
    assign acked       = (state == REQ) & bus.ram_ack;
    assign unused_page = ^bus.cpu_addr[15:14];

`ifdef MSX2_RAM_ACCESS_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_reg;

    // Count reaches 254 in the 255th REQ cycle; abort on that edge
    assign timed_out = (state == REQ) & ~bus.ram_ack & (tmo_cnt == 8'd254);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
            err_reg <= 1'b0;
        end else begin
            err_reg <= timed_out;
            if (start) begin
                tmo_cnt <= 8'd0;
            end else if (state == REQ) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    assign bus.err = err_reg;
`else
    assign timed_out = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                if (acked) begin
                    state_nxt = (abandoned | ~acc) ? IDLE : DONE;
                end else if (timed_out) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!acc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            served    <= 1'b0;
            abandoned <= 1'b0;
            data_reg  <= 8'hFF;
            addr_reg  <= 27'd0;
            rnw_reg   <= 1'b1;
            din_reg   <= 8'd0;
        end else begin
            state <= state_nxt;

            if (start) begin
                addr_reg  <= bus.base_addr + {5'd0, bus.segment, bus.cpu_addr[13:0]};
                rnw_reg   <= bus.cpu_rd;
                din_reg   <= bus.cpu_data;
                abandoned <= 1'b0;
            end else if ((state == REQ) && !acc) begin
                // Once the CPU lets go, this transfer's data belongs to nobody
                abandoned <= 1'b1;
            end

            if (acked && !abandoned && acc) begin
                served <= 1'b1;
                if (rnw_reg) data_reg <= bus.ram_dout;
            end else if (timed_out) begin
                served   <= 1'b1;
                data_reg <= 8'hFF;
            end else if ((state == DONE) && !acc) begin
                served <= 1'b0;
            end
        end
    end

    assign bus.ram_req  = (state == REQ);
    assign bus.ram_rnw  = rnw_reg;
    assign bus.ram_addr = addr_reg;
    assign bus.ram_din  = din_reg;
    assign bus.q        = ((state == DONE) && bus.cpu_rd && acc) ? data_reg : 8'hFF;
    assign bus.wait_n   = ~(acc && (state != DONE));

endmodule

`default_nettype wire

// File: tb/tb_msx2_ram_access.sv
//----------------------------------------------------------------------------
// Module : tb_msx2_ram_access
// Brief  : Randomized self-checking bench for msx2_ram_access with a
//          transaction-level reference model.
// Rev    : 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_msx2_ram_access;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    msx2_ram_access_if bus ();

    msx2_ram_access dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.sel      = 1'b0;
        bus.cpu_mreq = 1'b0;
        bus.cpu_rd   = 1'b0;
        bus.cpu_wr   = 1'b0;
        bus.ram_ack  = 1'b0;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [7:0] seg,
                         input logic [15:0] addr, input logic [26:0] base,
                         input logic [7:0] data);
        bus.sel       = 1'b1;
        bus.cpu_mreq  = 1'b1;
        bus.cpu_rd    = rd;
        bus.cpu_wr    = wr;
        bus.segment   = seg;
        bus.cpu_addr  = addr;
        bus.base_addr = base;
        bus.cpu_data  = data;
    endtask

    // Physical address: block base plus 22-bit (segment, page offset), modulo 2^27
    function automatic logic [26:0] model_addr(input logic [26:0] base, input logic [7:0] seg,
                                               input logic [15:0] addr);
        longint sum;
        sum = longint'(base) + longint'(seg) * 16384 + longint'(addr % 16384);
        return 27'(sum % (longint'(1) << 27));
    endfunction

    // One CPU access; lat = REQ cycle carrying ram_ack (0 = never acknowledge)
    task automatic do_access(input bit rd, input bit wr, input logic [7:0] seg,
                             input logic [15:0] addr, input logic [26:0] base,
                             input logic [7:0] data, input logic [7:0] dout,
                             input int lat, input int hold, input string name);
        int reqc = 0;
        int waitc = 0;
        int edges = 0;
        int errc = 0;
        bit prev = 1'b0;
        bit done = 1'b0;
        bit tmo = (lat == 0);
        logic [26:0] ea = model_addr(base, seg, addr);
        logic [7:0] eq = (!rd || tmo) ? 8'hFF : dout;
        drive(rd, wr, seg, addr, base, data);
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            bus.ram_ack = 1'b0;
            if (bus.ram_req) begin
                if (!prev) begin
                    edges++;
                    check({name, "_addr"}, 32'(bus.ram_addr), 32'(ea));
                    check({name, "_rnw"}, 32'(bus.ram_rnw), 32'(rd));
                    if (!rd) check({name, "_din"}, 32'(bus.ram_din), 32'(data));
                end
                reqc++;
                if (reqc == lat) begin
                    bus.ram_ack  = 1'b1;
                    bus.ram_dout = dout;
                    check({name, "_addr_hold"}, 32'(bus.ram_addr), 32'(ea));
                end
            end else if (prev) begin
                done = 1'b1;
            end
            prev = bus.ram_req;
            #1;
            if (!bus.wait_n) waitc++;
            if (bus.err) errc++;
            if (!done) tick();
        end
        check({name, "_completed"}, 32'(done), 32'd1);
        check({name, "_q"}, 32'(bus.q), 32'(eq));
        check({name, "_wait_done"}, 32'(bus.wait_n), 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            bus.ram_ack  = 1'($urandom % 2);
            bus.ram_dout = 8'($urandom);
            #1;
            if (bus.ram_req) edges++;
            if (bus.err) errc++;
            check({name, "_q_hold"}, 32'(bus.q), 32'(eq));
            check({name, "_wait_hold"}, 32'(bus.wait_n), 32'd1);
        end
        tick();
        idle_bus();
        #1;
        if (bus.ram_req) edges++;
        check({name, "_q_release"}, 32'(bus.q), 32'hFF);
        tick();
        check({name, "_req_count"}, 32'(edges), 32'd1);
        check({name, "_req_cycles"}, 32'(reqc), tmo ? 32'd255 : 32'(lat));
        check({name, "_wait_cycles"}, 32'(waitc), 32'(reqc + 1));
        check({name, "_err_pulses"}, 32'(errc), tmo ? 32'd1 : 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.cpu_addr  = 16'd0;
        bus.cpu_data  = 8'd0;
        bus.segment   = 8'd0;
        bus.base_addr = 27'd0;
        bus.ram_dout  = 8'd0;
        idle_bus();
        repeat (3) tick();
        check("rst_req", 32'(bus.ram_req), 32'd0);
        check("rst_rnw", 32'(bus.ram_rnw), 32'd1);
        check("rst_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_din", 32'(bus.ram_din), 32'd0);
        check("rst_q", 32'(bus.q), 32'hFF);
        check("rst_wait", 32'(bus.wait_n), 32'd1);
        check("rst_err", 32'(bus.err), 32'd0);
        reset = 1'b0;
        tick();

        do_access(1'b1, 1'b0, 8'd3, 16'h8005, 27'h100000, 8'h00, 8'h5A, 4, 2, "rd_basic");
        do_access(1'b0, 1'b1, 8'hFF, 16'hFFFF, 27'($urandom), 8'h33, 8'h00, 3, 2, "wr_top");
        do_access(1'b1, 1'b0, 8'h12, 16'h4321, 27'h0ABCDEF, 8'h00, 8'hC3, 1, 10, "rd_hold");
        do_access(1'b1, 1'b1, 8'h40, 16'h2001, 27'h0000100, 8'h99, 8'h3C, 2, 1, "rd_wr_both");
        do_access(1'b1, 1'b0, 8'h01, 16'h0000, 27'h7FFFFFF, 8'h00, 8'h81, 2, 1, "rd_wrap");

        // Reset in the middle of a transfer, then a stray acknowledge
        drive(1'b1, 1'b0, 8'h05, 16'h1234, 27'h0200000, 8'h00);
        repeat (3) tick();
        check("rstreq_pre", 32'(bus.ram_req), 32'd1);
        reset = 1'b1;
        #1;
        check("rstreq_req", 32'(bus.ram_req), 32'd0);
        check("rstreq_q", 32'(bus.q), 32'hFF);
        idle_bus();
        tick();
        reset        = 1'b0;
        bus.ram_ack  = 1'b1;
        bus.ram_dout = 8'hA5;
        tick();
        bus.ram_ack = 1'b0;
        #1;
        check("rstreq_req_after", 32'(bus.ram_req), 32'd0);
        check("rstreq_addr", 32'(bus.ram_addr), 32'd0);
        check("rstreq_rnw", 32'(bus.ram_rnw), 32'd1);
        check("rstreq_wait", 32'(bus.wait_n), 32'd1);

        // CPU abandons the access while the RAM is still busy
        drive(1'b1, 1'b0, 8'h07, 16'h0010, 27'h0000000, 8'h00);
        tick();
        check("abandon_req", 32'(bus.ram_req), 32'd1);
        tick();
        idle_bus();
        tick();
        bus.ram_ack  = 1'b1;
        bus.ram_dout = 8'h77;
        tick();
        bus.ram_ack = 1'b0;
        #1;
        check("abandon_req_drop", 32'(bus.ram_req), 32'd0);
        drive(1'b1, 1'b0, 8'h07, 16'h0010, 27'h0000000, 8'h00);
        #1;
        check("abandon_idle_wait", 32'(bus.wait_n), 32'd0);
        check("abandon_q", 32'(bus.q), 32'hFF);
        idle_bus();
        tick();
        tick();

`ifdef MSX2_RAM_ACCESS_TIMEOUT_EN
        do_access(1'b1, 1'b0, 8'h22, 16'hC000, 27'h0400000, 8'h00, 8'h00, 0, 2, "timeout");
`else
        do_access(1'b1, 1'b0, 8'h22, 16'hC000, 27'h0400000, 8'h00, 8'h6E, 1000, 1, "slow_ack");
`endif

        for (int i = 0; i < 25; i++) begin
            bit rd;
            bit wr;
            rd = 1'($urandom % 2);
            wr = rd ? 1'($urandom % 2) : 1'b1;
            do_access(rd, wr, 8'($urandom), 16'($urandom), 27'($urandom), 8'($urandom),
                      8'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(0, 3)),
                      "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/msx2_ram_access.md
MSX2_RAM_ACCESS -- requirements
Module: msx2_ram_access

Interface
REQ-001 The block SHALL have no parameters; widths SHALL be fixed as listed below.
REQ-002 clk  input  1  system clock; all state SHALL change on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_addr  input  16  CPU address bus.
REQ-005 cpu_data  input  8  CPU write data.
REQ-006 cpu_mreq, cpu_rd, cpu_wr  input  1 each  CPU memory request, read and write strobes, active-high.
REQ-007 sel  input  1  the slot decoder selects this RAM device.
REQ-008 segment  input  8  mapper segment for the page at cpu_addr[15:14], already masked to size.
REQ-009 base_addr  input  27  byte base of this device's block in external RAM.
REQ-010 ram_req  output  1  request to the external RAM controller.
REQ-011 ram_rnw  output  1  1 = read, 0 = write.
REQ-012 ram_addr  output  27  physical byte address.
REQ-013 ram_din  output  8  write data to RAM.
REQ-014 ram_ack  input  1  single-cycle completion pulse from the RAM controller.
REQ-015 ram_dout  input  8  read data, valid in the ram_ack cycle.
REQ-016 q  output  8  read data to the CPU bus, 8'hFF when not driving.
REQ-017 wait_n  output  1  CPU wait, active-low.
REQ-018 err  output  1  one-cycle pulse on access abort.

Function
REQ-019 Access strobe: acc = sel & cpu_mreq & (cpu_rd | cpu_wr).
REQ-020 FSM states: IDLE, REQ, DONE.
REQ-021 IDLE -> REQ when acc=1 and the served flag is 0.
- On that edge: latch ram_addr = base_addr + {segment, cpu_addr[13:0]} (22-bit offset zero-extended, sum modulo 2^27).
- Latch ram_rnw = cpu_rd and ram_din = cpu_data.
REQ-022 In REQ, ram_req SHALL be 1; ram_addr, ram_rnw and ram_din SHALL remain stable until ram_ack.
REQ-023 REQ -> DONE on ram_ack=1.
- ram_req drops on the same edge.
- If read, ram_dout is latched into the data register.
- The served flag is set.
REQ-024 In DONE: q = data register while cpu_rd & acc, else 8'hFF; DONE -> IDLE when acc=0, which also clears the served flag.
REQ-025 wait_n = 0 combinationally whenever acc=1 and state is not DONE (includes the detection cycle); otherwise 1.
REQ-026 If acc drops while in REQ, the transfer SHALL still complete, the data SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-027 If cpu_rd and cpu_wr are both 1, the access SHALL be treated as a read.
REQ-028 Back-to-back accesses need acc low for at least one cycle between them; one strobe SHALL yield exactly one ram_req transaction.
REQ-029 A ram_ack seen in IDLE or DONE SHALL be ignored.
REQ-030 Minimum read latency: strobe cycle N -> ram_req at N+1 -> ack at N+1 -> q valid and wait_n=1 at N+2.

Reset
REQ-031 Reset SHALL put the FSM in IDLE with: ram_req=0, ram_rnw=1, ram_addr=0, ram_din=0, data register=8'hFF, served flag=0, err=0, timeout counter=0.
REQ-032 Reset during REQ SHALL abort the access immediately; a later ram_ack SHALL be ignored.

Configuration
REQ-033 With macro MSX2_RAM_ACCESS_TIMEOUT_EN defined, an 8-bit counter SHALL run in REQ.
- The counter reaches 255 cycles without ram_ack: drop ram_req, load data register = 8'hFF, pulse err for one cycle, go to DONE.
- The counter clears on entry to REQ.
REQ-034 Without MSX2_RAM_ACCESS_TIMEOUT_EN, no counter SHALL be built, err SHALL be tied to 0, and REQ SHALL wait for ram_ack indefinitely.

Verification
REQ-035 Read: base=0x100000, segment=3, addr=0x8005, rd, ack after 4 cycles with dout=0x5A -> ram_addr=0x10C005, ram_rnw=1, wait_n low 5 cycles, then q=0x5A.
REQ-036 Write: segment=0xFF, addr=0xFFFF, data=0x33 -> ram_rnw=0, ram_din=0x33, ram_addr=base+0x3FFFFF, exactly one ram_req.
REQ-037 Strobe held 10 cycles after ack -> no second ram_req; wait_n=1; q stable until acc drops.
REQ-038 Reset asserted in REQ, then ram_ack -> ram_req=0, q=0xFF, FSM in IDLE, no latch.
REQ-039 TIMEOUT_EN build, no ack -> ram_req drops after 255 cycles, err pulses 1 cycle, q=0xFF, wait_n=1.
REQ-040 Non-TIMEOUT build, ack after 1000 cycles -> still completes correctly, err never asserted.
